// File: rtl/ysyx_22041071_mem_pkg.sv
// Shared widths, access-size encodings, opcodes and FSM states for the
// ysyx_22041071 memory stage.
package ysyx_22041071_mem_pkg;

    localparam int ADDR_BUS = 64;
    localparam int DATA_BUS = 64;
    localparam int INS_BUS  = 32;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [ADDR_BUS-1:0] pc;
        logic [INS_BUS-1:0]  ins;
        logic                rwen;
        logic [4:0]          rd;
        logic [DATA_BUS-1:0] alu;
        logic                load;
    } mem_pend_t;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        unique case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22041071_mem_stage_lsu_align.sv
// Byte-lane alignment: store mask/data generation and load extraction with
// sign/zero extension, keyed on access size, signedness and lane offset.
module ysyx_22041071_lsu_align
    import ysyx_22041071_mem_pkg::*;
(
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [2:0]          off_i,
    input  logic [DATA_BUS-1:0] st_data_i,
    input  logic [DATA_BUS-1:0] ld_raw_i,
    output logic [7:0]          wmask_o,
    output logic [DATA_BUS-1:0] wdata_o,
    output logic [DATA_BUS-1:0] ld_data_o,
    output logic                misalign_o
);

    logic [5:0]          bit_off;
    logic [DATA_BUS-1:0] sh;

    always_comb begin
        bit_off    = {off_i, 3'b000};
        wmask_o    = size_mask(size_i) << off_i;
        wdata_o    = st_data_i << bit_off;
        sh         = ld_raw_i >> bit_off;
        ld_data_o  = sh;
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_B: begin
                ld_data_o = unsigned_i ? {56'b0, sh[7:0]}
                                       : {{56{sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                ld_data_o  = unsigned_i ? {48'b0, sh[15:0]}
                                        : {{48{sh[15]}}, sh[15:0]};
                misalign_o = off_i[0];
            end
            SZ_W: begin
                ld_data_o  = unsigned_i ? {32'b0, sh[31:0]}
                                        : {{32{sh[31]}}, sh[31:0]};
                misalign_o = |off_i[1:0];
            end
            default: begin
                ld_data_o  = sh;
                misalign_o = |off_i;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22041071_mem_stage.sv
// MEM stage: accepts EX records, runs one blocking req/ack data-memory
// access for loads/stores, and presents a registered record to WB.
module ysyx_22041071_mem_stage
    import ysyx_22041071_mem_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                valid5,
    output logic                ready5,
    input  logic [ADDR_BUS-1:0] PC5,
    input  logic [INS_BUS-1:0]  Ins4,
    input  logic                MEM_W_en3,
    input  logic                WB_sel3,
    input  logic                reg_w_en3,
    input  logic [DATA_BUS-1:0] rt_data2,
    input  logic [4:0]          rdest2,
    input  logic [DATA_BUS-1:0] ALU_result1,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_BUS-1:0] mem_addr,
    output logic [DATA_BUS-1:0] mem_wdata,
    output logic [7:0]          mem_wmask,
    input  logic                mem_ack,
    input  logic [DATA_BUS-1:0] mem_rdata,
    output logic                valid6,
    input  logic                ready6,
    output logic [ADDR_BUS-1:0] PC6,
    output logic [INS_BUS-1:0]  Ins5,
    output logic                reg_w_en4,
    output logic [4:0]          rdest3,
    output logic [DATA_BUS-1:0] wb_data,
    output logic                misalign
);

    mem_state_e          state_q, state_d;
    mem_pend_t           pend_q;
    logic [1:0]          sz_q;
    logic                uns_q;
    logic [2:0]          off_q;
    logic                mem_req_q, mem_we_q, valid6_q, rwen4_q;
    logic [ADDR_BUS-1:0] mem_addr_q, pc6_q;
    logic [DATA_BUS-1:0] mem_wdata_q, wb_q;
    logic [7:0]          mem_wmask_q;
    logic [INS_BUS-1:0]  ins5_q;
    logic [4:0]          rd3_q;

    logic                memop, acc, fill_pt, fill_mem;
    logic [1:0]          al_size;
    logic                al_uns, al_mis;
    logic [2:0]          al_off;
    logic [7:0]          al_wmask;
    logic [DATA_BUS-1:0] al_wdata, al_ld;

    always_comb begin
        state_d = state_q;
        ready5  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready5 = !valid6_q | ready6;
                if (valid5 && ready5 && memop)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack)
                    state_d = S_IDLE;
            end
        endcase
    end

    assign memop    = MEM_W_en3 | WB_sel3;
    assign acc      = valid5 & ready5;
    assign fill_pt  = acc & !memop;
    assign fill_mem = (state_q == S_WAIT) & mem_ack;
    assign misalign = acc & memop & al_mis & !reset;

    // In WAIT the aligner serves load extraction from latched parameters.
    assign al_size = (state_q == S_WAIT) ? sz_q  : Ins4[13:12];
    assign al_uns  = (state_q == S_WAIT) ? uns_q : Ins4[14];
    assign al_off  = (state_q == S_WAIT) ? off_q : ALU_result1[2:0];

    ysyx_22041071_lsu_align u_align (
        .size_i     (al_size),
        .unsigned_i (al_uns),
        .off_i      (al_off),
        .st_data_i  (rt_data2),
        .ld_raw_i   (mem_rdata),
        .wmask_o    (al_wmask),
        .wdata_o    (al_wdata),
        .ld_data_o  (al_ld),
        .misalign_o (al_mis)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            sz_q        <= SZ_B;
            uns_q       <= 1'b0;
            off_q       <= 3'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            valid6_q    <= 1'b0;
            pc6_q       <= '0;
            ins5_q      <= '0;
            rwen4_q     <= 1'b0;
            rd3_q       <= '0;
            wb_q        <= '0;
        end else begin
            state_q <= state_d;
            if (acc && memop) begin
                pend_q      <= '{pc: PC5, ins: Ins4, rwen: reg_w_en3,
                                 rd: rdest2, alu: ALU_result1,
                                 load: WB_sel3 & !MEM_W_en3};
                sz_q        <= Ins4[13:12];
                uns_q       <= Ins4[14];
                off_q       <= ALU_result1[2:0];
                mem_req_q   <= 1'b1;
                mem_we_q    <= MEM_W_en3;
                mem_addr_q  <= {ALU_result1[63:3], 3'b000};
                mem_wdata_q <= al_wdata;
                mem_wmask_q <= al_wmask;
            end
            if (fill_mem)
                mem_req_q <= 1'b0;
            if (fill_pt) begin
                pc6_q   <= PC5;
                ins5_q  <= Ins4;
                rwen4_q <= reg_w_en3;
                rd3_q   <= rdest2;
                wb_q    <= ALU_result1;
            end else if (fill_mem) begin
                pc6_q   <= pend_q.pc;
                ins5_q  <= pend_q.ins;
                rwen4_q <= pend_q.rwen & pend_q.load;
                rd3_q   <= pend_q.rd;
                wb_q    <= pend_q.load ? al_ld : pend_q.alu;
            end
            if (fill_pt || fill_mem)
                valid6_q <= 1'b1;
            else if (valid6_q && ready6)
                valid6_q <= 1'b0;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign valid6    = valid6_q;
    assign PC6       = pc6_q;
    assign Ins5      = ins5_q;
    assign reg_w_en4 = rwen4_q;
    assign rdest3    = rd3_q;
    assign wb_data   = wb_q;

endmodule

// File: tb/tb_ysyx_22041071_mem_stage.sv
// Table-driven bench for the MEM stage with a WB-side scoreboard queue
// and hand-written back-pressure and reset-in-WAIT sequences.
module tb_ysyx_22041071_mem_stage;

    logic        clk = 1'b0;
    logic        reset, valid5, ready5;
    logic [63:0] PC5, rt_data2, ALU_result1;
    logic [31:0] Ins4, Ins5;
    logic        MEM_W_en3, WB_sel3, reg_w_en3;
    logic [4:0]  rdest2, rdest3;
    logic        mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        valid6, ready6, reg_w_en4, misalign;
    logic [63:0] PC6, wb_data;

    always #5 clk = ~clk;

    ysyx_22041071_mem_stage dut (
        .clk(clk), .reset(reset), .valid5(valid5), .ready5(ready5),
        .PC5(PC5), .Ins4(Ins4), .MEM_W_en3(MEM_W_en3), .WB_sel3(WB_sel3),
        .reg_w_en3(reg_w_en3), .rt_data2(rt_data2), .rdest2(rdest2),
        .ALU_result1(ALU_result1), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid6(valid6),
        .ready6(ready6), .PC6(PC6), .Ins5(Ins5), .reg_w_en4(reg_w_en4),
        .rdest3(rdest3), .wb_data(wb_data), .misalign(misalign)
    );

    typedef struct {
        logic        st;
        logic        ld;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        int          delay;
        logic        rwen;
        logic [4:0]  rd;
        logic [63:0] exp_wb;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        rwen;
        logic [4:0]  rd;
        logic [63:0] wb;
    } rec_t;

    vec_t vt[14];
    rec_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;
    vec_t va, vb, vr;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] mk_ins(input vec_t v);
        logic [6:0] opc;
        opc = v.st ? 7'b0100011 : (v.ld ? 7'b0000011 : 7'b0010011);
        return {17'h0, v.f3, v.rd, opc};
    endfunction

    task automatic drive(input vec_t v, input int idx);
        PC5         = 64'h8000_0000 + 64'(idx * 4);
        Ins4        = mk_ins(v);
        MEM_W_en3   = v.st;
        WB_sel3     = v.ld;
        reg_w_en3   = v.rwen;
        rt_data2    = v.sdata;
        rdest2      = v.rd;
        ALU_result1 = v.addr;
        valid5      = 1'b1;
    endtask

    task automatic send(input vec_t v, input int idx);
        rec_t r;
        int   n;
        drive(v, idx);
        n = 0;
        @(negedge clk);
        while (!ready5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(ready5 === 1'b1, "accept", 64'(ready5), 64'd1);
        chk(misalign === v.exp_mis, "misalign", 64'(misalign),
            64'(v.exp_mis));
        r.pc   = PC5;
        r.ins  = Ins4;
        r.rwen = v.st ? 1'b0 : v.rwen;
        r.rd   = v.rd;
        r.wb   = v.exp_wb;
        sbq.push_back(r);
        @(posedge clk); #1;
        valid5 = 1'b0;
        if (v.st || v.ld) begin
            for (int d = 0; d < v.delay; d++) begin
                @(negedge clk);
                chk(mem_req === 1'b1 && ready5 === 1'b0, "wait_req",
                    {62'b0, mem_req, ready5}, 64'h2);
                @(posedge clk); #1;
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            chk(mem_req === 1'b1 && mem_we === v.st && ready5 === 1'b0,
                "req_we", {61'b0, mem_req, mem_we, ready5},
                {61'b0, 1'b1, v.st, 1'b0});
            chk(mem_addr === (v.addr & ~64'h7), "addr", mem_addr,
                v.addr & ~64'h7);
            chk(mem_wmask === v.exp_mask, "wmask", 64'(mem_wmask),
                64'(v.exp_mask));
            chk(mem_wdata === v.exp_wdata, "wdata", mem_wdata,
                v.exp_wdata);
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            @(negedge clk);
            chk(valid6 === 1'b1, "ack_latency", 64'(valid6), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && valid6 === 1'b1 && ready6 === 1'b1) begin
            if (sbq.size() == 0) begin
                chk(1'b0, "unexpected_wb", wb_data, 64'd0);
            end else begin
                rec_t e;
                e = sbq.pop_front();
                chk(PC6 === e.pc && Ins5 === e.ins && reg_w_en4 === e.rwen
                    && rdest3 === e.rd && wb_data === e.wb, "wb_record",
                    wb_data, e.wb);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // st ld f3 addr sdata rdata delay rwen rd exp_wb mask wdata mis
        vt[0]  = '{0, 0, 3'd0, 64'h1234, 0, 0, 0, 1, 5'd5,
                   64'h1234, 8'h00, 64'h0, 0};
        vt[1]  = '{0, 0, 3'd0, 64'hDEAD_BEEF, 0, 0, 0, 1, 5'd7,
                   64'hDEAD_BEEF, 8'h00, 64'h0, 0};
        vt[2]  = '{0, 0, 3'd0, 64'hFFFF_0000_0000_0001, 0, 0, 0, 0, 5'd9,
                   64'hFFFF_0000_0000_0001, 8'h00, 64'h0, 0};
        vt[3]  = '{0, 1, 3'd0, 64'h1003, 0, 64'h0000_0000_8000_0000, 3, 1,
                   5'd10, 64'hFFFF_FFFF_FFFF_FF80, 8'h08, 64'h0, 0};
        vt[4]  = '{0, 1, 3'd4, 64'h1003, 0, 64'h0000_0000_8000_0000, 3, 1,
                   5'd11, 64'h80, 8'h08, 64'h0, 0};
        vt[5]  = '{1, 0, 3'd1, 64'h2006, 64'hABCD, 0, 1, 1, 5'd12,
                   64'h2006, 8'hC0, 64'hABCD_0000_0000_0000, 0};
        vt[6]  = '{0, 1, 3'd2, 64'h12, 0, 64'h1122_3344_5566_7788, 0, 1,
                   5'd13, 64'h3344_5566, 8'h3C, 64'h0, 1};
        vt[7]  = '{0, 1, 3'd3, 64'h40, 0, 64'hFEDC_BA98_7654_3210, 2, 1,
                   5'd14, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h0, 0};
        vt[8]  = '{0, 1, 3'd1, 64'h4, 0, 64'h0000_8001_0000_0000, 1, 1,
                   5'd15, 64'hFFFF_FFFF_FFFF_8001, 8'h30, 64'h0, 0};
        vt[9]  = '{0, 1, 3'd6, 64'h4, 0, 64'h8765_4321_0000_0000, 0, 1,
                   5'd16, 64'h8765_4321, 8'hF0, 64'h0, 0};
        vt[10] = '{1, 0, 3'd3, 64'h8, 64'h0102_0304_0506_0708, 0, 2, 1,
                   5'd17, 64'h8, 8'hFF, 64'h0102_0304_0506_0708, 0};
        vt[11] = '{1, 0, 3'd0, 64'h1, 64'hFF5A, 0, 1, 0, 5'd18,
                   64'h1, 8'h02, 64'h0000_0000_00FF_5A00, 0};
        vt[12] = '{0, 1, 3'd1, 64'h21, 0, 64'h0000_0000_0012_3400, 0, 1,
                   5'd19, 64'h1234, 8'h06, 64'h0, 1};
        vt[13] = '{1, 0, 3'd3, 64'h5, 64'h11, 0, 1, 1, 5'd20,
                   64'h5, 8'hE0, 64'h0000_1100_0000_0000, 1};

        reset = 1'b1; valid5 = 1'b0; PC5 = '0; Ins4 = '0;
        MEM_W_en3 = 1'b0; WB_sel3 = 1'b0; reg_w_en3 = 1'b0;
        rt_data2 = '0; rdest2 = '0; ALU_result1 = '0;
        mem_ack = 1'b0; mem_rdata = '0; ready6 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(ready5 === 1'b1, "rst_ready5", 64'(ready5), 64'd1);
        chk(mem_req === 1'b0 && mem_we === 1'b0 && mem_wmask === 8'h0,
            "rst_bus", {mem_req, mem_we, mem_wmask}, 64'd0);
        chk(valid6 === 1'b0 && wb_data === 64'd0 && PC6 === 64'd0,
            "rst_wb", wb_data, 64'd0);
        chk(misalign === 1'b0 && reg_w_en4 === 1'b0 && rdest3 === 5'd0,
            "rst_misc", {misalign, reg_w_en4, rdest3}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Pass-through records issued back to back.
        for (int i = 0; i < 3; i++) send(vt[i], i);
        for (int i = 3; i < 14; i++) send(vt[i], i);

        // Back-pressure: hold A, then drain A and accept B together.
        ready6 = 1'b0;
        va = vt[0]; va.addr = 64'hAAAA; va.exp_wb = 64'hAAAA; va.rd = 5'd21;
        vb = vt[1]; vb.addr = 64'hBBBB; vb.exp_wb = 64'hBBBB; vb.rd = 5'd22;
        send(va, 40);
        fork
            send(vb, 41);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk(ready5 === 1'b0, "bp_ready5", 64'(ready5), 64'd0);
                    chk(valid6 === 1'b1 && wb_data === 64'hAAAA,
                        "bp_hold", wb_data, 64'hAAAA);
                end
                @(posedge clk); #1;
                ready6 = 1'b1;
            end
        join
        @(negedge clk);
        chk(valid6 === 1'b1 && wb_data === 64'hBBBB, "refill",
            wb_data, 64'hBBBB);
        repeat (2) @(posedge clk);
        #1;

        // Reset in WAIT, followed by a late ack.
        vr = vt[7];
        drive(vr, 50);
        @(negedge clk);
        chk(ready5 === 1'b1, "rw_accept", 64'(ready5), 64'd1);
        @(posedge clk); #1;
        valid5 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk(mem_req === 1'b1 && ready5 === 1'b0, "rw_wait",
            {mem_req, ready5}, 64'h2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk(mem_req === 1'b0 && valid6 === 1'b0 && ready5 === 1'b1,
            "rw_abort", {mem_req, valid6, ready5}, 64'h1);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk(valid6 === 1'b0 && mem_req === 1'b0, "late_ack",
            {valid6, mem_req}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk(sbq.size() == 0, "sb_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
